// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - Decode->Execute pipeline register bundle
// Purpose: groups hazard controls, decode-stage inputs, execute-stage outputs and NZCV flags.
// Ports (via modports):
//   slave  : the pipeline register (consumes *D, StallE, FlushE, NextFlagsE; drives *E, ValidE, FlagsE)
//   master : the decode/hazard side driving the register and observing its outputs
interface id_ex_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
);
    logic               StallE;
    logic               FlushE;
    logic [3:0]         CondD,       CondE;
    logic [1:0]         FlagWriteD,  FlagWriteE;
    logic               BranchD,     BranchE;
    logic               RegWriteD,   RegWriteE;
    logic               MemWriteD,   MemWriteE;
    logic               MemtoRegD,   MemtoRegE;
    logic               PCSrcD,      PCSrcE;
    logic               NoWriteD,    NoWriteE;
    logic               ALUSrcD,     ALUSrcE;
    logic [1:0]         ALUControlD, ALUControlE;
    logic [DATA_W-1:0]  RD1D,        RD1E;
    logic [DATA_W-1:0]  RD2D,        RD2E;
    logic [DATA_W-1:0]  ExtImmD,     ExtImmE;
    logic [RADDR_W-1:0] RA1D,        RA1E;
    logic [RADDR_W-1:0] RA2D,        RA2E;
    logic [RADDR_W-1:0] WA3D,        WA3E;
    logic [3:0]         NextFlagsE;
    logic               ValidE;
    logic [3:0]         FlagsE;

    modport slave (
        input  StallE, FlushE, CondD, FlagWriteD, BranchD, RegWriteD, MemWriteD,
               MemtoRegD, PCSrcD, NoWriteD, ALUSrcD, ALUControlD, RD1D, RD2D,
               ExtImmD, RA1D, RA2D, WA3D, NextFlagsE,
        output CondE, FlagWriteE, BranchE, RegWriteE, MemWriteE, MemtoRegE,
               PCSrcE, NoWriteE, ALUSrcE, ALUControlE, RD1E, RD2E, ExtImmE,
               RA1E, RA2E, WA3E, ValidE, FlagsE
    );

    modport master (
        output StallE, FlushE, CondD, FlagWriteD, BranchD, RegWriteD, MemWriteD,
               MemtoRegD, PCSrcD, NoWriteD, ALUSrcD, ALUControlD, RD1D, RD2D,
               ExtImmD, RA1D, RA2D, WA3D, NextFlagsE,
        input  CondE, FlagWriteE, BranchE, RegWriteE, MemWriteE, MemtoRegE,
               PCSrcE, NoWriteE, ALUSrcE, ALUControlE, RD1E, RD2E, ExtImmE,
               RA1E, RA2E, WA3E, ValidE, FlagsE
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - Decode->Execute pipeline register with NZCV flags register
// Purpose: registers decode-stage control/data into E with stall/flush handling, and
//          commits NextFlagsE into FlagsE when a valid instruction leaves E.
// Ports:
//   clk        : core clock, rising edge
//   reset      : synchronous, active-high
//   bus        : id_ex_pipe_reg_if.slave (all *D inputs, *E outputs, ValidE, FlagsE)
//   BubbleCnt  : (PERF_CNT_EN only) saturating count of bubbles leaving E
//   StallCnt   : (PERF_CNT_EN only) saturating count of stalled cycles
// Configuration macro: PERF_CNT_EN
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef PERF_CNT_EN
    output logic [15:0]          BubbleCnt,
    output logic [15:0]          StallCnt,
`endif
    id_ex_pipe_reg_if.slave      bus
);
    // 15 control bits followed by three data words and three register addresses.
    localparam int PW = 15 + 3*DATA_W + 3*RADDR_W;

    logic [PW-1:0] payload_in;
    logic [PW-1:0] pipe_d,  pipe_q;
    logic          valid_d, valid_q;
    logic [3:0]    flags_d, flags_q;

    assign payload_in = {bus.CondD, bus.FlagWriteD, bus.BranchD, bus.RegWriteD,
                         bus.MemWriteD, bus.MemtoRegD, bus.PCSrcD, bus.NoWriteD,
                         bus.ALUSrcD, bus.ALUControlD, bus.RD1D, bus.RD2D,
                         bus.ExtImmD, bus.RA1D, bus.RA2D, bus.WA3D};

    // Flush clears data too, so a bubble never carries stale operands forward.
    always_comb begin
        pipe_d  = pipe_q;
        valid_d = valid_q;
        if (bus.FlushE) begin
            pipe_d  = '0;
            valid_d = 1'b0;
        end else if (!bus.StallE) begin
            pipe_d  = payload_in;
            valid_d = 1'b1;
        end
    end

    // The retiring instruction commits regardless of flush; a stalled one must
    // not commit, or a held conditional op would observe its own update.
    always_comb begin
        flags_d = flags_q;
        if (valid_q && !bus.StallE) begin
            flags_d = bus.NextFlagsE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q  <= '0;
            valid_q <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            pipe_q  <= pipe_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign {bus.CondE, bus.FlagWriteE, bus.BranchE, bus.RegWriteE,
            bus.MemWriteE, bus.MemtoRegE, bus.PCSrcE, bus.NoWriteE,
            bus.ALUSrcE, bus.ALUControlE, bus.RD1E, bus.RD2E,
            bus.ExtImmE, bus.RA1E, bus.RA2E, bus.WA3E} = pipe_q;
    assign bus.ValidE = valid_q;
    assign bus.FlagsE = flags_q;

`ifdef PERF_CNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;
    logic [15:0] stall_cnt_d,  stall_cnt_q;

    // Both counters saturate rather than wrap.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!valid_q && !bus.StallE && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (bus.StallE && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign BubbleCnt = bubble_cnt_q;
    assign StallCnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  fw;
        logic        br, rw, mw, m2r, pcs, nw, alusrc;
        logic [1:0]  aluc;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  ra1, ra2, wa3;
    } stage_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.DATA_W(DW), .RADDR_W(AW)) bus ();

`ifdef PERF_CNT_EN
    logic [15:0] bubble_cnt, stall_cnt;
    id_ex_pipe_reg #(.DATA_W(DW), .RADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .BubbleCnt(bubble_cnt), .StallCnt(stall_cnt), .bus(bus));
`else
    id_ex_pipe_reg #(.DATA_W(DW), .RADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    stage_t     d_in;
    logic       stall, flush;
    logic [3:0] next_flags;

    // Reference model state
    stage_t     m_e;
    bit         m_valid;
    logic [3:0] m_flags;
    int         m_bub, m_stall;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic stage_t observed();
        stage_t s;
        s = '{bus.CondE, bus.FlagWriteE, bus.BranchE, bus.RegWriteE, bus.MemWriteE,
              bus.MemtoRegE, bus.PCSrcE, bus.NoWriteE, bus.ALUSrcE, bus.ALUControlE,
              bus.RD1E, bus.RD2E, bus.ExtImmE, bus.RA1E, bus.RA2E, bus.WA3E};
        return s;
    endfunction

    task automatic drive();
        bus.StallE      = stall;
        bus.FlushE      = flush;
        bus.NextFlagsE  = next_flags;
        bus.CondD       = d_in.cond;
        bus.FlagWriteD  = d_in.fw;
        bus.BranchD     = d_in.br;
        bus.RegWriteD   = d_in.rw;
        bus.MemWriteD   = d_in.mw;
        bus.MemtoRegD   = d_in.m2r;
        bus.PCSrcD      = d_in.pcs;
        bus.NoWriteD    = d_in.nw;
        bus.ALUSrcD     = d_in.alusrc;
        bus.ALUControlD = d_in.aluc;
        bus.RD1D        = d_in.rd1;
        bus.RD2D        = d_in.rd2;
        bus.ExtImmD     = d_in.imm;
        bus.RA1D        = d_in.ra1;
        bus.RA2D        = d_in.ra2;
        bus.WA3D        = d_in.wa3;
    endtask

    task automatic rand_d();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        d_in = r[122:0];
    endtask

    // One clock: inputs already driven; apply the rules to the model at the edge,
    // optionally compare 1 time unit later, then return at the falling edge.
    task automatic step(input string tag, input bit do_chk);
        bit retiring;
        @(posedge clk);
        retiring = m_valid;
        if (reset) begin
            m_e = '0; m_valid = 0; m_flags = 4'b0000; m_bub = 0; m_stall = 0;
        end else begin
            if (!m_valid && !stall && m_bub < 65535) m_bub++;
            if (stall && m_stall < 65535) m_stall++;
            if (retiring && !stall) m_flags = next_flags;
            if (flush) begin
                m_e = '0; m_valid = 0;
            end else if (!stall) begin
                m_e = d_in; m_valid = 1;
            end
        end
        #1;
        if (do_chk) begin
            chk({tag, "_e"},     128'(observed()),  128'(m_e));
            chk({tag, "_valid"}, 128'(bus.ValidE),  128'(m_valid));
            chk({tag, "_flags"}, 128'(bus.FlagsE),  128'(m_flags));
`ifdef PERF_CNT_EN
            chk({tag, "_bub"},   128'(bubble_cnt),  128'(m_bub));
            chk({tag, "_stall"}, 128'(stall_cnt),   128'(m_stall));
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        m_e = '0; m_valid = 0; m_flags = '0; m_bub = 0; m_stall = 0;
        stall = 0; flush = 0; next_flags = 4'hF; reset = 1;
        rand_d(); drive();

        // 1. reset with random D inputs
        step("rst0", 1'b1);
        rand_d(); drive();
        step("rst1", 1'b1);
        chk("rst_regwrite", 128'(bus.RegWriteE), 128'd0);
        chk("rst_flags",    128'(bus.FlagsE),    128'd0);
        chk("rst_valid",    128'(bus.ValidE),    128'd0);
        reset = 0;

        // 2. ADDS load, then flag commit one edge later
        rand_d();
        d_in.cond = 4'hE; d_in.fw = 2'b11; d_in.rw = 1'b1; d_in.rd1 = 32'd5; d_in.rd2 = 32'd7;
        next_flags = 4'b0100; drive();
        step("adds_load", 1'b1);
        chk("adds_rd1",   128'(bus.RD1E),     128'd5);
        chk("adds_rd2",   128'(bus.RD2E),     128'd7);
        chk("adds_cond",  128'(bus.CondE),    128'hE);
        chk("adds_flags_pre", 128'(bus.FlagsE), 128'd0);
        rand_d(); drive();
        step("adds_commit", 1'b1);
        chk("adds_flags", 128'(bus.FlagsE), 128'b0100);

        // 3. stall 3 cycles: contents and flags held, commit on release
        stall = 1; next_flags = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            rand_d(); drive();
            step("stall", 1'b1);
        end
        chk("stall_flags_held", 128'(bus.FlagsE), 128'b0100);
        stall = 0; rand_d(); drive();
        step("stall_release", 1'b1);
        chk("release_flags", 128'(bus.FlagsE), 128'b1000);

        // 4. flush kills incoming writes; retiring instruction still commits
        flush = 1; next_flags = 4'b0011; rand_d(); d_in.rw = 1; d_in.mw = 1; drive();
        step("flush", 1'b1);
        chk("flush_regwrite", 128'(bus.RegWriteE), 128'd0);
        chk("flush_memwrite", 128'(bus.MemWriteE), 128'd0);
        chk("flush_valid",    128'(bus.ValidE),    128'd0);
        chk("flush_commit",   128'(bus.FlagsE),    128'b0011);
        // bubble in E: no commit
        flush = 0; next_flags = 4'b1111; rand_d(); drive();
        step("bubble", 1'b1);
        chk("bubble_flags", 128'(bus.FlagsE), 128'b0011);

        // 5. flush+stall -> bubble; reset during stall clears everything
        rand_d(); drive(); step("reload", 1'b1);
        flush = 1; stall = 1; rand_d(); drive();
        step("flush_stall", 1'b1);
        chk("flush_stall_valid", 128'(bus.ValidE), 128'd0);
        flush = 0; stall = 0; rand_d(); drive(); step("reload2", 1'b1);
        stall = 1; rand_d(); drive(); step("pre_rst_stall", 1'b1);
        reset = 1; next_flags = 4'b1010; rand_d(); drive();
        step("rst_in_stall", 1'b1);
        chk("rst_in_stall_flags", 128'(bus.FlagsE), 128'd0);
        chk("rst_in_stall_valid", 128'(bus.ValidE), 128'd0);
        reset = 0; stall = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_d();
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 4) == 0);
            reset      = ($urandom_range(0, 40) == 0);
            next_flags = 4'($urandom());
            drive();
            step("rand", 1'b1);
        end
        reset = 0;

`ifdef PERF_CNT_EN
        // 6. counters: flushes then loads, then drive stall count to saturation
        reset = 1; stall = 0; flush = 0; drive(); step("pc_rst", 1'b1);
        reset = 0; flush = 1; drive();
        for (int i = 0; i < 4; i++) step("pc_flush", 1'b1);
        flush = 0;
        for (int i = 0; i < 4; i++) begin rand_d(); drive(); step("pc_load", 1'b1); end
        stall = 1; drive();
        for (int i = 0; i < 65540; i++) step("pc_sat", 1'b0);
        step("pc_sat_end", 1'b1);
        chk("stallcnt_sat", 128'(stall_cnt), 128'hFFFF);
        stall = 0; drive();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
